// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, format codes and the decoded-field bundle.
package rv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FN3_W   = 3;
  localparam int unsigned FN7_W   = 7;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6,
    FMT_SYS  = 3'd7
  } fmt_e;

  // Width-independent part of the decoded bundle; imm and pc are carried beside it at XLEN.
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [FN3_W-1:0] fn3;
    logic             fn7_5;
    fmt_e             fmt;
    logic             illegal;
  } dec_fields_t;

  localparam dec_fields_t DEC_RESET = '{
    opcode:  '0,
    rd:      '0,
    rs1:     '0,
    rs2:     '0,
    fn3:     '0,
    fn7_5:   1'b0,
    fmt:     FMT_NONE,
    illegal: 1'b0
  };

  function automatic fmt_e opcode_fmt(input logic [OPC_W-1:0] op);
    fmt_e f;
    case (op)
      OP_R:                       f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:   f = FMT_I;
      OP_STORE:                   f = FMT_S;
      OP_BRANCH:                  f = FMT_B;
      OP_LUI, OP_AUIPC:           f = FMT_U;
      OP_JAL:                     f = FMT_J;
      OP_FENCE, OP_SYSTEM:        f = FMT_SYS;
      default:                    f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv_decode_stage_imm_gen.sv
// Combinational format classifier and sign-extended immediate generator.
module rv_imm_gen import rv_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output fmt_e               fmt_c,
  output logic [XLEN-1:0]    imm_c
);

  logic [31:0] imm32;
  logic        sgn;

  always_comb begin
    fmt_c = opcode_fmt(instr[OPC_W-1:0]);
  end

  // Build the 32-bit immediate, then sign-extend to the datapath width.
  always_comb begin
    sgn   = instr[31];
    imm32 = '0;
    case (fmt_c)
      FMT_I, FMT_SYS: imm32 = {{20{sgn}}, instr[31:20]};
      FMT_S:          imm32 = {{20{sgn}}, instr[31:25], instr[11:7]};
      FMT_B:          imm32 = {{19{sgn}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:          imm32 = {instr[31:12], 12'b0};
      FMT_J:          imm32 = {{11{sgn}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:        imm32 = '0;
    endcase
    imm_c = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake, flush and decoded-instruction counter.
module rv_decode_stage import rv_pkg::*; #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     CNT_W    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_rs1,
  output logic [REG_W-1:0]   out_rs2,
  output logic [FN3_W-1:0]   out_fn3,
  output logic               out_fn7_5,
  output logic [2:0]         out_fmt,
  output logic [XLEN-1:0]    out_imm,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   decoded_count
);

  fmt_e             fmt_c;
  logic [XLEN-1:0]  imm_c;
  dec_fields_t      dec_c;
  logic [OPC_W-1:0] opcode;
  logic [FN3_W-1:0] fn3;
  logic [FN7_W-1:0] fn7;
  logic             is_shift_imm;
  logic             xfer;
  logic             fire;

  logic             valid_q, valid_d;
  dec_fields_t      dec_q, dec_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt_c (fmt_c),
    .imm_c (imm_c)
  );

  // Field extraction: indices and funct bits only where the format defines them.
  always_comb begin
    opcode       = in_instr[6:0];
    fn3          = in_instr[14:12];
    fn7          = in_instr[31:25];
    is_shift_imm = (opcode == OP_IMM) && ((fn3 == 3'b001) || (fn3 == 3'b101));
    dec_c        = DEC_RESET;
    dec_c.opcode = opcode;
    dec_c.fmt    = fmt_c;
    case (fmt_c)
      FMT_R: begin
        dec_c.rd    = in_instr[11:7];
        dec_c.rs1   = in_instr[19:15];
        dec_c.rs2   = in_instr[24:20];
        dec_c.fn3   = fn3;
        dec_c.fn7_5 = in_instr[30];
      end
      FMT_I, FMT_SYS: begin
        dec_c.rd    = in_instr[11:7];
        dec_c.rs1   = in_instr[19:15];
        dec_c.fn3   = fn3;
        dec_c.fn7_5 = is_shift_imm ? in_instr[30] : 1'b0;
      end
      FMT_S, FMT_B: begin
        dec_c.rs1 = in_instr[19:15];
        dec_c.rs2 = in_instr[24:20];
        dec_c.fn3 = fn3;
      end
      FMT_U, FMT_J: begin
        dec_c.rd = in_instr[11:7];
      end
      default: ;
    endcase

    // Illegal-encoding screen over the RV32I base set.
    case (opcode)
      OP_R: begin
        if (fn7 == 7'h20)      dec_c.illegal = !((fn3 == 3'b000) || (fn3 == 3'b101));
        else if (fn7 != 7'h00) dec_c.illegal = 1'b1;
      end
      OP_IMM: begin
        if (fn3 == 3'b001)      dec_c.illegal = (fn7 != 7'h00);
        else if (fn3 == 3'b101) dec_c.illegal = (fn7 != 7'h00) && (fn7 != 7'h20);
      end
      OP_JALR:   dec_c.illegal = (fn3 != 3'b000);
      OP_LOAD:   dec_c.illegal = (fn3 == 3'b011) || (fn3 == 3'b110) || (fn3 == 3'b111);
      OP_STORE:  dec_c.illegal = (fn3 > 3'b010);
      OP_BRANCH: dec_c.illegal = (fn3 == 3'b010) || (fn3 == 3'b011);
      OP_JAL, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: dec_c.illegal = 1'b0;
      default:   dec_c.illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) dec_c.illegal = 1'b1;
  end

  assign in_ready = !valid_q || out_ready;

  // Next-state: flush drops both the held bundle and any same-cycle input.
  always_comb begin
    xfer    = in_valid && in_ready && !flush;
    fire    = valid_q && out_ready && !flush;
    valid_d = valid_q;
    dec_d   = dec_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    count_d = count_q + CNT_W'(fire);
    if (flush)         valid_d = 1'b0;
    else if (in_ready) valid_d = in_valid;
    if (xfer) begin
      dec_d = dec_c;
      imm_d = imm_c;
      pc_d  = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      dec_q   <= DEC_RESET;
      imm_q   <= '0;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_opcode    = dec_q.opcode;
  assign out_rd        = dec_q.rd;
  assign out_rs1       = dec_q.rs1;
  assign out_rs2       = dec_q.rs2;
  assign out_fn3       = dec_q.fn3;
  assign out_fn7_5     = dec_q.fn7_5;
  assign out_fmt       = dec_q.fmt;
  assign out_imm       = imm_q;
  assign out_illegal   = dec_q.illegal;
  assign decoded_count = count_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: 32-bit and 64-bit instances driven in lockstep, checked against a spec-level model.
module tb_rv_decode_stage;
  import rv_pkg::*;

  localparam logic [31:0] RPC_A = 32'h0000_0080;
  localparam logic [63:0] RPC_B = 64'hFFFF_0000_0000_0100;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] pc;

  logic        in_ready_a, out_valid_a, fn7_5_a, illegal_a;
  logic [31:0] pc_a, imm_a, count_a;
  logic [6:0]  opcode_a;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [2:0]  fn3_a, fmt_a;

  logic        in_ready_b, out_valid_b, fn7_5_b, illegal_b;
  logic [63:0] pc_b, imm_b;
  logic [3:0]  count_b;
  logic [6:0]  opcode_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [2:0]  fn3_b, fmt_b;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32), .CNT_W(32), .RESET_PC(RPC_A)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_pc(pc[31:0]), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(pc_a), .out_opcode(opcode_a), .out_rd(rd_a), .out_rs1(rs1_a), .out_rs2(rs2_a),
    .out_fn3(fn3_a), .out_fn7_5(fn7_5_a), .out_fmt(fmt_a), .out_imm(imm_a),
    .out_illegal(illegal_a), .decoded_count(count_a)
  );

  rv_decode_stage #(.XLEN(64), .CNT_W(4), .RESET_PC(RPC_B)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_pc(pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(pc_b), .out_opcode(opcode_b), .out_rd(rd_b), .out_rs1(rs1_b), .out_rs2(rs2_b),
    .out_fn3(fn3_b), .out_fn7_5(fn7_5_b), .out_fmt(fmt_b), .out_imm(imm_b),
    .out_illegal(illegal_b), .decoded_count(count_b)
  );

  typedef struct {
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  fn3;
    logic        fn7_5;
    logic [2:0]  fmt;
    longint      imm;
    logic        illegal;
    logic [63:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned exp_cnt;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Decode from the ISA tables: immediates via weighted bit fields and a signed MSB.
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] p);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit u_rd, u_rs1, u_rs2, u_f3;
    longint neg, ival, sval, bval, uval, jval;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    neg  = i[31] ? 64'sd1 : 64'sd0;
    ival = longint'(i[31:20]) - neg * 4096;
    sval = longint'(i[31:25]) * 32 + longint'(i[11:7]) - neg * 4096;
    bval = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2 - neg * 4096;
    uval = longint'(i[31:12]) * 4096 - neg * 64'sh1_0000_0000;
    jval = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2
           - neg * 1048576;
    u_rd = 0; u_rs1 = 0; u_rs2 = 0; u_f3 = 0;
    e.fn7_5 = 1'b0; e.illegal = 1'b0; e.imm = 0; e.fmt = FMT_NONE;
    e.opcode = op; e.pc = p;
    case (op)
      7'h33: begin
        e.fmt = FMT_R; u_rd = 1; u_rs1 = 1; u_rs2 = 1; u_f3 = 1; e.fn7_5 = i[30];
        e.illegal = !(f7 inside {7'h00, 7'h20}) || (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}));
      end
      7'h13: begin
        e.fmt = FMT_I; u_rd = 1; u_rs1 = 1; u_f3 = 1; e.imm = ival;
        e.fn7_5 = (f3 inside {3'd1, 3'd5}) ? i[30] : 1'b0;
        e.illegal = (f3 == 3'd1 && f7 != 0) || (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}));
      end
      7'h03: begin
        e.fmt = FMT_I; u_rd = 1; u_rs1 = 1; u_f3 = 1; e.imm = ival;
        e.illegal = f3 inside {3'd3, 3'd6, 3'd7};
      end
      7'h67: begin
        e.fmt = FMT_I; u_rd = 1; u_rs1 = 1; u_f3 = 1; e.imm = ival; e.illegal = (f3 != 0);
      end
      7'h23: begin
        e.fmt = FMT_S; u_rs1 = 1; u_rs2 = 1; u_f3 = 1; e.imm = sval; e.illegal = (f3 > 3'd2);
      end
      7'h63: begin
        e.fmt = FMT_B; u_rs1 = 1; u_rs2 = 1; u_f3 = 1; e.imm = bval;
        e.illegal = f3 inside {3'd2, 3'd3};
      end
      7'h6F: begin e.fmt = FMT_J; u_rd = 1; e.imm = jval; end
      7'h37, 7'h17: begin e.fmt = FMT_U; u_rd = 1; e.imm = uval; end
      7'h0F, 7'h73: begin e.fmt = FMT_SYS; u_rd = 1; u_rs1 = 1; u_f3 = 1; e.imm = ival; end
      default: e.illegal = 1'b1;
    endcase
    e.rd  = u_rd  ? i[11:7]  : 5'd0;
    e.rs1 = u_rs1 ? i[19:15] : 5'd0;
    e.rs2 = u_rs2 ? i[24:20] : 5'd0;
    e.fn3 = u_f3  ? f3       : 3'd0;
    return e;
  endfunction

  task automatic check_outputs();
    exp_t e;
    bit   v;
    v = (exp_q.size() > 0);
    chk("valid_a", 64'(out_valid_a), 64'(v));
    chk("valid_b", 64'(out_valid_b), 64'(v));
    chk("count_a", 64'(count_a), 64'(exp_cnt));
    chk("count_b", 64'(count_b), 64'(exp_cnt % 16));
    if (v) begin
      e = exp_q[0];
      chk("opcode", 64'(opcode_a), 64'(e.opcode));
      chk("rd", 64'(rd_a), 64'(e.rd));
      chk("rs1", 64'(rs1_a), 64'(e.rs1));
      chk("rs2", 64'(rs2_a), 64'(e.rs2));
      chk("fn3", 64'(fn3_a), 64'(e.fn3));
      chk("fn7_5", 64'(fn7_5_a), 64'(e.fn7_5));
      chk("fmt", 64'(fmt_a), 64'(e.fmt));
      chk("illegal", 64'(illegal_a), 64'(e.illegal));
      chk("imm_a", 64'(imm_a), 64'(e.imm[31:0]));
      chk("pc_a", 64'(pc_a), 64'(e.pc[31:0]));
      chk("imm_b", imm_b, e.imm);
      chk("pc_b", pc_b, e.pc);
      chk("illegal_b", 64'(illegal_b), 64'(e.illegal));
      chk("fmt_b", 64'(fmt_b), 64'(e.fmt));
    end
  endtask

  // One clock of stimulus; the scoreboard holds at most the one bundle the stage should present.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    bit exp_rdy, acc;
    in_valid = v; in_instr = ins; out_ready = rdy; flush = fl;
    #1;
    exp_rdy = (exp_q.size() == 0) || rdy;
    chk("in_ready_a", 64'(in_ready_a), 64'(exp_rdy));
    chk("in_ready_b", 64'(in_ready_b), 64'(exp_rdy));
    acc = v && exp_rdy && !fl;
    if (exp_q.size() > 0 && rdy && !fl) exp_cnt++;
    if (exp_q.size() > 0 && (rdy || fl)) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(model(ins, pc));
    @(posedge clk);
    #1;
    check_outputs();
    pc = pc + 64'd4;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1; in_instr = 32'h0020_A423;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    chk("rst_valid", 64'(out_valid_a), 64'd0);
    chk("rst_illegal", 64'(illegal_a), 64'd0);
    chk("rst_fmt", 64'(fmt_a), 64'(FMT_NONE));
    chk("rst_fields", 64'({opcode_a, rd_a, rs1_a, rs2_a, fn3_a, fn7_5_a}), 64'd0);
    chk("rst_imm", 64'(imm_a), 64'd0);
    chk("rst_pc_a", 64'(pc_a), 64'(RPC_A));
    chk("rst_count_a", 64'(count_a), 64'd0);
    chk("rst_valid_b", 64'(out_valid_b), 64'd0);
    chk("rst_pc_b", pc_b, RPC_B);
    chk("rst_imm_b", imm_b, 64'd0);
    chk("rst_count_b", 64'(count_b), 64'd0);
  endtask

  logic [31:0] legal_ops [11];

  initial begin
    checks = 0; failures = 0; exp_cnt = 0;
    pc = 64'h0000_0000_0000_1000;
    legal_ops = '{32'h33, 32'h13, 32'h03, 32'h23, 32'h63, 32'h6F, 32'h67, 32'h37,
                  32'h17, 32'h0F, 32'h73};
    do_reset();

    // addi x1,x0,-1 then drain
    cyc(1, 32'hFFF0_0093, 1, 0);
    chk("addi_imm", 64'(imm_a), 64'hFFFF_FFFF);
    chk("addi_rd", 64'(rd_a), 64'd1);
    chk("addi_fmt", 64'(fmt_a), 64'(FMT_I));
    cyc(0, 32'h0, 1, 0);
    chk("addi_count", 64'(count_a), 64'd1);

    // sw x2,8(x1), then jal x0,-4
    cyc(1, 32'h0020_A423, 1, 0);
    chk("sw_imm", 64'(imm_a), 64'd8);
    chk("sw_regs", 64'({rd_a, rs1_a, rs2_a, fn3_a}), 64'({5'd0, 5'd1, 5'd2, 3'b010}));
    cyc(1, 32'hFFDF_F06F, 1, 0);
    chk("jal_imm64", imm_b, 64'hFFFF_FFFF_FFFF_FFFC);

    // Backpressure: three stalled cycles, then release; B must follow A exactly once
    cyc(1, 32'h0050_0113, 1, 0);
    for (int k = 0; k < 3; k++) cyc(1, 32'h0030_8193, 0, 0);
    cyc(1, 32'h0030_8193, 1, 0);
    chk("bp_b_imm", 64'(imm_a), 64'd3);
    cyc(1, 32'h4020_81B3, 1, 0);
    cyc(0, 32'h0, 1, 0);

    // Illegal encodings
    cyc(1, 32'h0000_0000, 1, 0);
    chk("ill_zero", 64'({illegal_a, fmt_a}), 64'({1'b1, 3'(FMT_NONE)}));
    cyc(1, 32'h4000_1033, 1, 0);
    chk("ill_sub_fn3", 64'(illegal_a), 64'd1);
    cyc(1, 32'h0000_3003, 1, 0);
    chk("ill_ld", 64'(illegal_a), 64'd1);

    // Flush with a held bundle and a same-cycle input
    cyc(1, 32'h0010_0093, 0, 0);
    cyc(1, 32'h0020_0113, 1, 1);
    chk("flush_valid", 64'(out_valid_a), 64'd0);
    cyc(1, 32'h0070_0393, 1, 0);
    chk("post_flush_imm", 64'(imm_a), 64'd7);

    // Reset mid-stream while a bundle is valid
    cyc(1, 32'h1234_50B7, 0, 0);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins = {ins[31:7], legal_ops[$urandom_range(0, 10)][6:0]};
      if ($urandom_range(0, 7) == 0) pc = {$urandom, $urandom};
      cyc(1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
Registered, parametrised RV32I instruction-decode pipeline stage and successor to the combinational field decoder. It accepts a fetched instruction and PC over a valid/ready handshake and extracts register indices, funct fields and a fully sign-extended, format-correct immediate at XLEN width. It also flags illegal encodings and keeps a count of decoded instructions. It sits between fetch and the register-file/execute stage, with flush support for taken branches and jumps.

Parameters:
XLEN, 32, datapath width for immediate and PC (legal: 32 or 64; encoding is always RV32I)
CNT_W, 32, width of decoded-instruction counter
RESET_PC, 0, value driven on out_pc during reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  drops stage contents this cycle
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
in_instr  in  32  raw instruction
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts
out_pc  out  XLEN  registered PC
out_opcode  out  7  instr[6:0]
out_rd / out_rs1 / out_rs2  out  5 each  register indices, 0 when unused by format
out_fn3  out  3  funct3, 0 when unused
out_fn7_5  out  1  instr[30] for R-type and shift-immediates, else 0
out_fmt  out  3  format code (package enum)
out_imm  out  XLEN  sign-extended immediate
out_illegal  out  1  illegal-encoding flag
decoded_count  out  CNT_W  accepted output handshakes

Behaviour:
- Reset: out_valid=0, out_illegal=0, out_fmt=FMT_NONE; out_rd/rs1/rs2/fn3/fn7_5/opcode=0; out_imm=0; out_pc=RESET_PC; decoded_count=0. Reset overrides flush and handshakes.
- in_ready = !out_valid || out_ready (combinational). A transfer occurs when in_valid && in_ready.
- Latency is 1 cycle. On a transfer, all outputs load the decode of in_instr/in_pc and out_valid=1. If out_ready && !in_valid, out_valid becomes 0 and the data registers hold.
- Stall: while out_valid && !out_ready, every output is held stable.
- flush: next out_valid=0 and any same-cycle input is discarded (in_ready may be 1, but the transfer is dropped). decoded_count is not incremented for a flushed output.
- decoded_count increments on out_valid && out_ready && !flush and wraps modulo 2^CNT_W.
- Formats and immediates (sign bit instr[31] replicated to XLEN):
  - R: no immediate, imm=0.
  - I (OP-IMM, LOAD, JALR): instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U (LUI, AUIPC): {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - SYS (FENCE, SYSTEM): I-field, with rd/rs1/fn3 populated.
- out_illegal=1 when any of:
  - opcode is not one of the 11 RV32I opcodes.
  - R-type funct7 is not 0x00 or 0x20.
  - R-type funct7=0x20 with fn3 not 000 or 101.
  - SLLI with instr[31:25]≠0.
  - SRLI/SRAI with instr[31:25] not 0x00 or 0x20.
  - JALR fn3≠0.
  - LOAD fn3 in {011, 110, 111}.
  - STORE fn3>010.
  - BRANCH fn3 in {010, 011}.
  - instr[1:0]≠11.
- Illegal instructions still flow through the stage with fields decoded as far as the opcode permits; fmt=FMT_NONE for unknown opcodes.

Decomposition:
- Package rv_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM);
  - fmt enum (FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS);
  - the decoded-bundle struct.
- One combinational sub-module, rv_imm_gen (instr → fmt, imm at XLEN), feeds the pipeline register. Illegal checking stays in the top-level module.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1 → next cycle: out_valid=1, fmt=I, rd=1, rs1=0, imm=0xFFFFFFFF, illegal=0; decoded_count=1 after acceptance.
- sw x2,8(x1) (0x0020A423) → fmt=S, rs1=1, rs2=2, fn3=010, rd=0, imm=0x00000008. With XLEN=64, jal x0,-4 (0xFFDFF06F) → imm=0xFFFFFFFFFFFFFFFC.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable, count unchanged; release → one transfer per cycle and no instruction lost or duplicated.
- Illegal encodings:
  - 0x00000000 → illegal=1, fmt=FMT_NONE.
  - 0x40001033 (funct7=0x20, fn3=001) → illegal=1.
  - 0x00003003 (LD on RV32) → illegal=1.
- flush asserted while out_valid=1 and in_valid=1 → next cycle out_valid=0 and count unchanged; the following instruction decodes normally.
- Assert rst mid-stream with out_valid=1 → next cycle all outputs at reset values, out_pc=RESET_PC, decoded_count=0.
